cell_cdc_hs_src: RTL and testbench

CELL_CDC_HS_SRC -- requirements
Module: cell_cdc_hs_src

---
 rtl/cell_cdc_hs_src.sv | 123 ++++++++++++
 tb/tb_cell_cdc_hs_src.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_cdc_hs_src.sv
// Source side of a two-phase (toggle) request/ack clock-domain crossing.
// A word is captured into XDATA, XREQ toggles one cycle later, and the block
// waits for the synchronised ack toggle to match XREQ before taking another.
module cell_cdc_hs_src #(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             IN_READY,
    output logic [WIDTH-1:0] XDATA,
    output logic             XREQ,
    input  logic             XACK,
    output logic             DONE,
    output logic             TIMEOUT_ERR
);

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT
    } state_e;

    state_e           state_q, state_d;
    logic             ack_s1_q, ack_s2_q;
    logic [1:0]       settle_q;
    logic             xreq_q, xreq_d;
    logic [WIDTH-1:0] xdata_q, xdata_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             terr_q, terr_d;
    logic             ack_match;
    logic             accept;

    assign ack_match = (ack_s2_q == xreq_q);
    assign accept    = IN_VALID && IN_READY;

    // State register, forced back to IDLE by reset.
    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept in IDLE, one SETUP cycle, then wait for the ack toggle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = SETUP;
            SETUP:                  state_d = WAIT;
            WAIT:    if (ack_match) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Ready gating and next values of the data, request, counter and pulse flops.
    // settle_q keeps IN_READY low until ack_s2 has had two cycles to reflect XACK
    // after reset, so a stale ack level is never mistaken for a matching one.
    always_comb begin
        IN_READY = RN && settle_q[1] && (state_q == IDLE) && ack_match;
        xdata_d  = xdata_q;
        xreq_d   = xreq_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        terr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) xdata_d = IN_DATA;
            end
            SETUP: begin
                xreq_d = ~xreq_q;
                cnt_d  = '0;
            end
            WAIT: begin
                if (ack_match) begin
                    done_d = 1'b1;
                end else begin
                    if (cnt_q != TMAX) cnt_d = cnt_q + CW'(1);
                    if ((TIMEOUT_CYC != 0) && (cnt_q != TMAX) && (cnt_d == TMAX)) terr_d = 1'b1;
                end
            end
            default: begin
                xreq_d = xreq_q;
            end
        endcase
    end

    // Datapath registers, ack synchroniser and post-reset settle shift register.
    always_ff @(posedge CK) begin
        if (!RN) begin
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
            settle_q <= 2'b00;
            xreq_q   <= 1'b0;
            xdata_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            ack_s1_q <= XACK;
            ack_s2_q <= ack_s1_q;
            settle_q <= {settle_q[0], 1'b1};
            xreq_q   <= xreq_d;
            xdata_q  <= xdata_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
        end
    end

    assign XDATA       = xdata_q;
    assign XREQ        = xreq_q;
    assign DONE        = done_q;
    assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_cell_cdc_hs_src.sv
// Directed bench for cell_cdc_hs_src with a scoreboard of offered words.
module tb_cell_cdc_hs_src;

    localparam int WIDTH = 8;
    localparam int TO    = 16;

    logic             ck = 1'b0;
    logic             rn;
    logic             inValid;
    logic [WIDTH-1:0] inData;
    logic             inReady;
    logic [WIDTH-1:0] xdata;
    logic             xreq;
    logic             xack;
    logic             done;
    logic             timeoutErr;

    int               checks = 0;
    int               errors = 0;
    int               donePulses = 0;
    int               toPulses = 0;
    logic [WIDTH-1:0] expQ[$];

    cell_cdc_hs_src #(.WIDTH(WIDTH), .TIMEOUT_CYC(TO)) dut (
        .CK          (ck),
        .RN          (rn),
        .IN_VALID    (inValid),
        .IN_DATA     (inData),
        .IN_READY    (inReady),
        .XDATA       (xdata),
        .XREQ        (xreq),
        .XACK        (xack),
        .DONE        (done),
        .TIMEOUT_ERR (timeoutErr)
    );

    // Free-running clock.
    always #5 ck = ~ck;

    // Pulse counters sampled away from the active edge.
    always @(negedge ck) begin
        if (done === 1'b1) donePulses++;
        if (timeoutErr === 1'b1) toPulses++;
    end

    // Hard stop in case a bounded wait is somehow bypassed.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
        checks++;
        assert (obs === expVal) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expVal);
        end
    endtask

    // Offer a word (leaves IN_VALID high) and wait, bounded, for the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] word);
        int n;
        n       = 0;
        inValid = 1'b1;
        inData  = word;
        expQ.push_back(word);
        while (inReady !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        checkOutput("acceptReady", {31'd0, inReady}, 1);
        tick;
    endtask

    // Destination view: request toggle observed, word popped from scoreboard.
    task automatic expectRequest(input logic expReq);
        logic [WIDTH-1:0] w;
        checkOutput("xreqToggle", {31'd0, xreq}, {31'd0, expReq});
        if (expQ.size() > 0) begin
            w = expQ.pop_front();
            checkOutput("xdataScoreboard", {24'd0, xdata}, {24'd0, w});
        end else begin
            checkOutput("scoreboardUnderflow", expQ.size(), 1);
        end
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            checkOutput("noTimeoutWhileWaiting", {31'd0, timeoutErr}, 0);
            tick;
            n++;
        end
        checkOutput("doneSeen", {31'd0, done}, 1);
        checkOutput("noTimeoutWithDone", {31'd0, timeoutErr}, 0);
    endtask

    task automatic doReset;
        rn      = 1'b0;
        inValid = 1'b0;
        xack    = 1'b0;
        tick;
        rn = 1'b1;
        tick;
        tick;
    endtask

    initial begin
        int d0;
        int t0;
        rn      = 1'b0;
        inValid = 1'b0;
        inData  = '0;
        xack    = 1'b0;
        tick;
        tick;

        // Reset state.
        checkOutput("rstXreq", {31'd0, xreq}, 0);
        checkOutput("rstXdata", {24'd0, xdata}, 0);
        checkOutput("rstDone", {31'd0, done}, 0);
        checkOutput("rstTimeout", {31'd0, timeoutErr}, 0);
        checkOutput("rstReady", {31'd0, inReady}, 0);
        rn = 1'b1;
        checkOutput("settleReady0", {31'd0, inReady}, 0);
        tick;
        checkOutput("settleReady1", {31'd0, inReady}, 0);
        tick;
        checkOutput("readyAfterReset", {31'd0, inReady}, 1);

        // Single transfer of 0xA5, ack three cycles after the request.
        applyStimulus(8'hA5);
        inValid = 1'b0;
        checkOutput("t1Xdata", {24'd0, xdata}, 32'hA5);
        checkOutput("t1XreqBefore", {31'd0, xreq}, 0);
        checkOutput("t1ReadyBusy", {31'd0, inReady}, 0);
        tick;
        expectRequest(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick;
            checkOutput("t1NoEarlyDone", {31'd0, done}, 0);
        end
        xack = 1'b1;
        tick;
        checkOutput("t1Sync1", {31'd0, done}, 0);
        tick;
        checkOutput("t1Sync2", {31'd0, done}, 0);
        checkOutput("t1Sync2Ready", {31'd0, inReady}, 0);
        tick;
        checkOutput("t1Done", {31'd0, done}, 1);
        checkOutput("t1ReadyWithDone", {31'd0, inReady}, 1);
        tick;
        checkOutput("t1DoneOnce", {31'd0, done}, 0);

        // Two words with IN_VALID held continuously.
        doReset;
        d0 = donePulses;
        applyStimulus(8'h11);
        inData = 8'h22;
        expQ.push_back(8'h22);
        tick;
        expectRequest(1'b1);
        xack = 1'b1;
        for (int i = 0; i < 10 && done !== 1'b1; i++) begin
            checkOutput("t2XdataHeld", {24'd0, xdata}, 32'h11);
            tick;
        end
        checkOutput("t2FirstDone", {31'd0, done}, 1);
        checkOutput("t2XdataAtDone", {24'd0, xdata}, 32'h11);
        tick;
        checkOutput("t2SecondWord", {24'd0, xdata}, 32'h22);
        tick;
        inValid = 1'b0;
        expectRequest(1'b0);
        xack = 1'b0;
        waitDone(10);
        for (int i = 0; i < 5; i++) tick;
        checkOutput("t2DonePulses", donePulses - d0, 2);

        // Timeout with no ack, then a late ack still completes.
        doReset;
        t0 = toPulses;
        applyStimulus(8'h3C);
        inValid = 1'b0;
        tick;
        expectRequest(1'b1);
        for (int i = 1; i < TO; i++) begin
            tick;
            checkOutput("t3NoEarlyTimeout", {31'd0, timeoutErr}, 0);
        end
        tick;
        checkOutput("t3TimeoutPulse", {31'd0, timeoutErr}, 1);
        tick;
        checkOutput("t3TimeoutOnce", {31'd0, timeoutErr}, 0);
        for (int i = TO + 2; i <= 40; i++) begin
            tick;
            checkOutput("t3StillWaiting", {31'd0, done}, 0);
        end
        xack = 1'b1;
        waitDone(10);
        tick;
        checkOutput("t3TimeoutPulses", toPulses - t0, 1);
        checkOutput("t3ReadyAfter", {31'd0, inReady}, 1);

        // Ack level high across reset release blocks acceptance.
        rn   = 1'b0;
        xack = 1'b1;
        tick;
        tick;
        rn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("t4StaleAckBlocks", {31'd0, inReady}, 0);
            tick;
        end
        xack = 1'b0;
        tick;
        checkOutput("t4AckSyncing", {31'd0, inReady}, 0);
        tick;
        checkOutput("t4ReadyRestored", {31'd0, inReady}, 1);

        // Reset one cycle after the request toggles aborts the transfer.
        d0 = donePulses;
        applyStimulus(8'h5A);
        inValid = 1'b0;
        tick;
        expectRequest(1'b1);
        rn   = 1'b0;
        xack = 1'b1;
        tick;
        checkOutput("t5XreqCleared", {31'd0, xreq}, 0);
        checkOutput("t5XdataCleared", {24'd0, xdata}, 0);
        checkOutput("t5NoDone", {31'd0, done}, 0);
        rn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            checkOutput("t5BlockedByAck", {31'd0, inReady}, 0);
        end
        xack = 1'b0;
        tick;
        tick;
        checkOutput("t5ReadyIdle", {31'd0, inReady}, 1);
        checkOutput("t5NoDonePulses", donePulses - d0, 0);

        // Ack change during SETUP is only evaluated once in WAIT.
        applyStimulus(8'h96);
        inValid = 1'b0;
        xack    = 1'b1;
        tick;
        expectRequest(1'b1);
        checkOutput("t6NoDoneSetup", {31'd0, done}, 0);
        tick;
        checkOutput("t6NoDoneWait", {31'd0, done}, 0);
        tick;
        checkOutput("t6Done", {31'd0, done}, 1);
        tick;
        checkOutput("t6DoneOnce", {31'd0, done}, 0);
        checkOutput("t6ReadyAfter", {31'd0, inReady}, 1);

        checkOutput("scoreboardDrained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
